// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: halt opcode,
// NOP encoding, opcode field geometry and FSM state encoding.
package fetch_pkg;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] HALT_OPCODE_DEF = 6'b111111;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_e;

endpackage : fetch_pkg

// File: rtl/fetch_imem.sv
// Instruction memory: synchronous write port for debug loading,
// combinational read port for fetch. Contents are not reset.
module fetch_imem #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    // Debug-load write, independent of pipeline enable
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : fetch_imem

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID register, hazard stall, branch
// redirect with squash, and halt detection.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned          PC_W        = 32,
    parameter int unsigned          DATA_W      = 32,
    parameter int unsigned          IMEM_ADDR_W = 8,
    parameter logic [PC_W-1:0]      RESET_PC    = '0,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE = HALT_OPCODE_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic                   i_stall,
    input  logic                   i_branch_taken,
    input  logic [PC_W-1:0]        i_branch_target,
    input  logic                   i_flush,
    input  logic                   i_load_we,
    input  logic [IMEM_ADDR_W-1:0] i_load_addr,
    input  logic [DATA_W-1:0]      i_load_data,
    output logic [PC_W-1:0]        o_pc,
    output logic [PC_W-1:0]        o_pc_plus4,
    output logic [DATA_W-1:0]      o_instr,
    output logic                   o_valid,
    output logic                   o_halted
);

    localparam logic [PC_W-1:0]   PC_INC = PC_W'(4);
    localparam logic [DATA_W-1:0] NOP    = DATA_W'(NOP_INSTR);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc4_q, pc4_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    fetch_state_e      state_q, state_d;

    logic [DATA_W-1:0] fetch_instr;
    logic [PC_W-1:0]   pc_plus4;
    logic              fetch_is_halt;

    fetch_imem #(
        .DATA_W (DATA_W),
        .ADDR_W (IMEM_ADDR_W)
    ) u_imem (
        .clk     (clk),
        .we_i    (i_load_we),
        .waddr_i (i_load_addr),
        .wdata_i (i_load_data),
        .raddr_i (pc_q[IMEM_ADDR_W+1:2]),
        .rdata_o (fetch_instr)
    );

    assign pc_plus4      = pc_q + PC_INC;
    assign fetch_is_halt = (fetch_instr[DATA_W-1 -: OPCODE_W] == HALT_OPCODE);

    // Next PC, IF/ID contents and FSM state; everything holds by default
    always_comb begin
        pc_d    = pc_q;
        pc4_d   = pc4_q;
        instr_d = instr_q;
        valid_d = valid_q;
        state_d = state_q;
        // A debug load freezes the pipeline for the cycle, FSM included
        if (i_enable && !i_load_we) begin
            if (i_branch_taken) begin
                pc_d    = {i_branch_target[PC_W-1:2], 2'b00};
                pc4_d   = '0;
                instr_d = NOP;
                valid_d = 1'b0;
                state_d = ST_RUN;
            end else if (i_stall) begin
                if (i_flush) begin
                    pc4_d   = '0;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end
            end else if (state_q == ST_HALTED) begin
                pc4_d   = '0;
                instr_d = NOP;
                valid_d = 1'b0;
            end else begin
                if (!fetch_is_halt) begin
                    pc_d = pc_plus4;
                end
                if (i_flush) begin
                    pc4_d   = '0;
                    instr_d = NOP;
                    valid_d = 1'b0;
                end else begin
                    pc4_d   = pc_plus4;
                    instr_d = fetch_instr;
                    valid_d = 1'b1;
                    if (fetch_is_halt) begin
                        state_d = ST_HALTED;
                    end
                end
            end
        end
    end

    // PC, IF/ID register and FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            pc4_q   <= '0;
            instr_q <= NOP;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
        end else begin
            pc_q    <= pc_d;
            pc4_q   <= pc4_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            state_q <= state_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc4_q;
    assign o_instr    = instr_q;
    assign o_valid    = valid_q;
    assign o_halted   = (state_q == ST_HALTED);

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_enable;
    logic        i_stall;
    logic        i_branch_taken;
    logic [31:0] i_branch_target;
    logic        i_flush;
    logic        i_load_we;
    logic [7:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic [31:0] o_pc;
    logic [31:0] o_pc_plus4;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .PC_W        (32),
        .DATA_W      (32),
        .IMEM_ADDR_W (8),
        .RESET_PC    (32'h0),
        .HALT_OPCODE (6'b111111)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_enable        (i_enable),
        .i_stall         (i_stall),
        .i_branch_taken  (i_branch_taken),
        .i_branch_target (i_branch_target),
        .i_flush         (i_flush),
        .i_load_we       (i_load_we),
        .i_load_addr     (i_load_addr),
        .i_load_data     (i_load_data),
        .o_pc            (o_pc),
        .o_pc_plus4      (o_pc_plus4),
        .o_instr         (o_instr),
        .o_valid         (o_valid),
        .o_halted        (o_halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        i_load_we   = 1'b1;
        i_load_addr = addr;
        i_load_data = data;
        tick();
        i_load_we   = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (o_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want %h", o_pc, 32'h0); end
        n_checks++;
        if (o_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL reset_pc4: got %h want %h", o_pc_plus4, 32'h0); end
        n_checks++;
        if (o_instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want %h", o_instr, 32'h0); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b want 0", o_halted); end
    endtask

    // Runs the three-word program from a freshly reset PC; ends in HALTED.
    task automatic test_fetch_halt();
        logic [31:0] exp_instr [3];
        logic [31:0] exp_pc [3];
        exp_instr[0] = 32'h2001_0005; exp_pc[0] = 32'h4;
        exp_instr[1] = 32'h2002_0007; exp_pc[1] = 32'h8;
        exp_instr[2] = 32'hFC00_0000; exp_pc[2] = 32'h8;
        i_enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (o_instr !== exp_instr[i]) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h want %h", i, o_instr, exp_instr[i]); end
            n_checks++;
            if (o_pc_plus4 !== 32'(4 * (i + 1))) begin n_fail++; $display("FAIL seq_pc4[%0d]: got %h want %h", i, o_pc_plus4, 32'(4 * (i + 1))); end
            n_checks++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL seq_valid[%0d]: got %b want 1", i, o_valid); end
            n_checks++;
            if (o_pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, o_pc, exp_pc[i]); end
            n_checks++;
            if (o_halted !== (i == 2)) begin n_fail++; $display("FAIL seq_halted[%0d]: got %b want %b", i, o_halted, (i == 2)); end
        end
        tick();
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL halt_nop_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_instr !== 32'h0) begin n_fail++; $display("FAIL halt_nop_instr: got %h want 0", o_instr); end
        n_checks++;
        if (o_pc !== 32'h8) begin n_fail++; $display("FAIL halt_pc_hold: got %h want %h", o_pc, 32'h8); end
        n_checks++;
        if (o_halted !== 1'b1) begin n_fail++; $display("FAIL halt_stays: got %b want 1", o_halted); end
    endtask

    task automatic test_halt_release();
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h0;
        tick();
        i_branch_taken  = 1'b0;
        n_checks++;
        if (o_halted !== 1'b0) begin n_fail++; $display("FAIL release_halted: got %b want 0", o_halted); end
        n_checks++;
        if (o_pc !== 32'h0) begin n_fail++; $display("FAIL release_pc: got %h want 0", o_pc); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", o_valid); end
        tick();
        n_checks++;
        if (o_instr !== 32'h2001_0005) begin n_fail++; $display("FAIL release_instr: got %h want %h", o_instr, 32'h2001_0005); end
        n_checks++;
        if (o_pc !== 32'h4) begin n_fail++; $display("FAIL release_pc_next: got %h want 4", o_pc); end
    endtask

    task automatic test_stall();
        i_stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_checks++;
            if (o_pc !== 32'h4) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want 4", i, o_pc); end
            n_checks++;
            if (o_instr !== 32'h2001_0005) begin n_fail++; $display("FAIL stall_instr[%0d]: got %h want %h", i, o_instr, 32'h2001_0005); end
            n_checks++;
            if (o_pc_plus4 !== 32'h4) begin n_fail++; $display("FAIL stall_pc4[%0d]: got %h want 4", i, o_pc_plus4); end
            n_checks++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", i, o_valid); end
        end
        i_stall = 1'b0;
        tick();
        n_checks++;
        if (o_pc !== 32'h8) begin n_fail++; $display("FAIL stall_resume_pc: got %h want 8", o_pc); end
        n_checks++;
        if (o_instr !== 32'h2002_0007) begin n_fail++; $display("FAIL stall_resume_instr: got %h want %h", o_instr, 32'h2002_0007); end
        n_checks++;
        if (o_pc_plus4 !== 32'h8) begin n_fail++; $display("FAIL stall_resume_pc4: got %h want 8", o_pc_plus4); end
    endtask

    task automatic test_branch_over_stall();
        i_stall         = 1'b1;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h43;
        tick();
        i_stall         = 1'b0;
        i_branch_taken  = 1'b0;
        n_checks++;
        if (o_pc !== 32'h40) begin n_fail++; $display("FAIL br_pc: got %h want %h", o_pc, 32'h40); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL br_squash_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_pc_plus4 !== 32'h0) begin n_fail++; $display("FAIL br_squash_pc4: got %h want 0", o_pc_plus4); end
        tick();
        n_checks++;
        if (o_instr !== 32'h1122_3344) begin n_fail++; $display("FAIL br_target_instr: got %h want %h", o_instr, 32'h1122_3344); end
        n_checks++;
        if (o_pc_plus4 !== 32'h44) begin n_fail++; $display("FAIL br_target_pc4: got %h want %h", o_pc_plus4, 32'h44); end
        n_checks++;
        if (o_valid !== 1'b1) begin n_fail++; $display("FAIL br_target_valid: got %b want 1", o_valid); end
    endtask

    task automatic test_enable_freeze();
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_load_we       = (i == 0);
            i_load_addr     = 8'd5;
            i_load_data     = 32'h20A5_A5A5;
            i_branch_taken  = (i == 1);
            i_branch_target = 32'h100;
            i_stall         = (i == 1);
            i_flush         = (i == 1);
            tick();
            n_checks++;
            if (o_pc !== 32'h44) begin n_fail++; $display("FAIL frz_pc[%0d]: got %h want %h", i, o_pc, 32'h44); end
            n_checks++;
            if (o_instr !== 32'h1122_3344) begin n_fail++; $display("FAIL frz_instr[%0d]: got %h want %h", i, o_instr, 32'h1122_3344); end
            n_checks++;
            if (o_valid !== 1'b1) begin n_fail++; $display("FAIL frz_valid[%0d]: got %b want 1", i, o_valid); end
        end
        i_load_we       = 1'b0;
        i_branch_taken  = 1'b0;
        i_stall         = 1'b0;
        i_flush         = 1'b0;
        i_enable        = 1'b1;
        i_branch_taken  = 1'b1;
        i_branch_target = 32'h14;
        tick();
        i_branch_taken  = 1'b0;
        n_checks++;
        if (o_pc !== 32'h14) begin n_fail++; $display("FAIL frz_redirect_pc: got %h want %h", o_pc, 32'h14); end
        tick();
        n_checks++;
        if (o_instr !== 32'h20A5_A5A5) begin n_fail++; $display("FAIL frz_loaded_instr: got %h want %h", o_instr, 32'h20A5_A5A5); end
        n_checks++;
        if (o_pc_plus4 !== 32'h18) begin n_fail++; $display("FAIL frz_loaded_pc4: got %h want %h", o_pc_plus4, 32'h18); end
    endtask

    task automatic test_flush();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n_checks++;
        if (o_pc !== 32'h1C) begin n_fail++; $display("FAIL flush_pc: got %h want %h", o_pc, 32'h1C); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", o_valid); end
        n_checks++;
        if (o_instr !== 32'h0) begin n_fail++; $display("FAIL flush_instr: got %h want 0", o_instr); end
    endtask

    task automatic test_load_hold();
        load_word(8'd7, 32'h0000_0007);
        n_checks++;
        if (o_pc !== 32'h1C) begin n_fail++; $display("FAIL ldhold_pc: got %h want %h", o_pc, 32'h1C); end
        n_checks++;
        if (o_valid !== 1'b0) begin n_fail++; $display("FAIL ldhold_valid: got %b want 0", o_valid); end
        tick();
        n_checks++;
        if (o_instr !== 32'h0000_0007) begin n_fail++; $display("FAIL ldhold_instr: got %h want %h", o_instr, 32'h7); end
        n_checks++;
        if (o_pc !== 32'h20) begin n_fail++; $display("FAIL ldhold_pc_next: got %h want %h", o_pc, 32'h20); end
    endtask

    task automatic test_reset_midrun();
        #3;
        rst = 1'b1;
        #1;
        test_reset();
        tick();
        rst = 1'b0;
        test_fetch_halt();
    endtask

    initial begin
        rst             = 1'b1;
        i_enable        = 1'b0;
        i_stall         = 1'b0;
        i_branch_taken  = 1'b0;
        i_branch_target = '0;
        i_flush         = 1'b0;
        i_load_we       = 1'b0;
        i_load_addr     = '0;
        i_load_data     = '0;
        #1;
        test_reset();
        tick();
        tick();
        rst = 1'b0;
        load_word(8'd0,  32'h2001_0005);
        load_word(8'd1,  32'h2002_0007);
        load_word(8'd2,  32'hFC00_0000);
        load_word(8'd6,  32'h0000_0006);
        load_word(8'd16, 32'h1122_3344);
        test_fetch_halt();
        test_halt_release();
        test_stall();
        test_branch_over_stall();
        test_enable_freeze();
        test_flush();
        test_load_hold();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_unit

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage with integrated IF/ID pipeline register, internal loadable instruction memory, hazard stall, branch redirect with squash, and halt detection. Sits at the front of the 5-stage pipeline: takes redirects from MEM, stalls from the hazard detection unit, and program/enable control from the debug unit; feeds the decode stage with a registered instruction, PC+4 and a valid bit.

## Interface
- `PC_W`, 32, PC and branch-target width
- `DATA_W`, 32, instruction width
- `IMEM_ADDR_W`, 8, word-address bits of the instruction memory (depth = 2^IMEM_ADDR_W words)
- `RESET_PC`, 0, PC value after reset
- `HALT_OPCODE`, 6'b111111, value of instr[DATA_W-1:DATA_W-6] that marks a halt instruction

- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: asynchronous, active-high reset
- `i_enable` in 1: run/step gate from the debug unit; 0 freezes PC, IF/ID and FSM
- `i_stall` in 1: hazard-unit stall; holds PC and IF/ID
- `i_branch_taken` in 1: redirect from MEM
- `i_branch_target` in PC_W: redirect address
- `i_flush` in 1: squash IF/ID without redirect
- `i_load_we` in 1: instruction-memory write strobe (debug load)
- `i_load_addr` in IMEM_ADDR_W: word address for load
- `i_load_data` in DATA_W: word to write
- `o_pc` out PC_W: current registered PC
- `o_pc_plus4` out PC_W: IF/ID copy of fetched PC + 4
- `o_instr` out DATA_W: IF/ID instruction
- `o_valid` out 1: IF/ID holds a real instruction
- `o_halted` out 1: FSM in HALTED

## Operation
- Memory read is combinational at word address pc[IMEM_ADDR_W+1:2]; upper PC bits ignored (aliasing). Write is synchronous on `i_load_we`, independent of `i_enable`. Contents not reset.
- FSM states: RUN, HALTED. RUN -> HALTED when an instruction with HALT_OPCODE is latched into IF/ID. HALTED -> RUN only on `i_branch_taken`. Reset -> RUN.
- PC update priority (when `i_enable`=1): `i_load_we` hold > `i_branch_taken` load {target[PC_W-1:2],2'b00} > `i_stall` hold > HALTED hold > fetched halt hold > pc+4 (modulo 2^PC_W).
- IF/ID update priority (when `i_enable`=1): `i_load_we` hold > `i_branch_taken` or `i_flush` load NOP (instr 0, valid 0, pc_plus4 0) > `i_stall` hold > HALTED load NOP > else load {mem[pc], pc+4, valid 1}.
- Branch overrides stall: MEM is never stalled, redirect must not be lost.
- Halt instruction itself enters IF/ID with valid=1; PC stays on the halt address; subsequent cycles insert NOPs.
- `i_enable`=0: PC, IF/ID, FSM hold; branch/flush/stall ignored that cycle.

## Timing
- Reset values: o_pc=RESET_PC, o_pc_plus4=0, o_instr=0, o_valid=0, o_halted=0.
- Fetch latency 1 cycle: instruction at PC p visible on o_instr the cycle after PC=p.
- Redirect: `i_branch_taken` sampled edge n -> o_pc=target after n; target instruction on o_instr after n+1; IF/ID squashed (valid 0) after n.
- o_halted asserts the same edge the halt instruction is latched.
- `rst` mid-operation clears immediately (asynchronous); memory contents retained.

## Structure
- Shared package `fetch_pkg`: HALT_OPCODE default, NOP encoding, FSM state encoding, opcode field position.
- One sub-module: `fetch_imem` (parametrised DATA_W x 2^IMEM_ADDR_W, sync write, async read).
- PC register, adder, IF/ID register and FSM stay in `fetch_unit`.

## Test plan
- Load 0x20010005 @0, 0x20020007 @1, halt 0xFC000000 @2; run -> o_instr sequence 0x20010005, 0x20020007, 0xFC000000 with o_pc_plus4 4, 8, 12; o_halted=1, o_pc stays 8, then valid=0.
- `i_stall` high 2 cycles while o_pc=4 -> o_pc=4 and IF/ID unchanged both cycles, resumes with o_pc=8.
- `i_branch_taken`=1, target=0x43 together with `i_stall`=1 -> o_pc=0x40 next cycle, o_valid=0; mem[16] appears on o_instr the following cycle.
- In HALTED, `i_branch_taken` target 0x0 -> o_halted=0, o_pc=0, fetch resumes from word 0.
- `i_enable`=0 for 3 cycles with `i_load_we` writing word 5 -> PC/IF/ID frozen, mem[5] updated and fetched correctly once enabled.
- Assert `rst` mid-run -> all outputs to reset values immediately, program memory preserved, re-run reproduces first scenario.
